// File: rtl/dc_ipu_shr_stream_source.sv
`default_nettype none
// ============================================================================
// Module : dc_ipu_shr_stream_source
// Reads a frame in raster order from 1-cycle-latency memory and streams it
// out over valid/ready with sof/eof/sol/eol flags.
// Rev    : 1.0  initial release
// ============================================================================

module dc_ipu_shr_stream_source #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clr,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_sol,
    output logic              out_eol
);

    localparam int ENT_W = DATA_W + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  width_q, width_d, height_q, height_d;
    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              infl_q, infl_d;
    logic [3:0]        infl_flags_q, infl_flags_d;
    logic [ENT_W-1:0]  fifo_q [2];
    logic [ENT_W-1:0]  fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic [CNT_W-1:0]  w_last, h_last;
    logic              x_at_end, last_px, fifo_nonempty, pop, issue, push;
    logic [1:0]        occ_after;
    logic [3:0]        issue_flags;
    logic [ENT_W-1:0]  infl_entry, head;

    assign w_last        = width_q - CNT_W'(1);
    assign h_last        = height_q - CNT_W'(1);
    assign x_at_end      = (x_q == w_last);
    assign last_px       = x_at_end && (y_q == h_last);
    assign issue_flags   = {(x_q == '0) && (y_q == '0), last_px, (x_q == '0), x_at_end};

    // The in-flight read acts as the FIFO write stage: while the FIFO is
    // empty its data is presented directly, otherwise it is pushed behind.
    assign infl_entry    = {mem_rd_data, infl_flags_q};
    assign fifo_nonempty = (count_q != 2'd0);
    assign out_valid     = fifo_nonempty | infl_q;
    assign pop           = out_valid & out_ready;
    assign push          = infl_q & ~(pop & ~fifo_nonempty);
    assign occ_after     = count_q + {1'b0, infl_q} - {1'b0, pop};
    assign issue         = (state_q == S_RUN) && (occ_after < 2'd2);

    always_comb begin
        head = '0;
        if (fifo_nonempty) begin
            head = fifo_q[rd_ptr_q];
        end else if (infl_q) begin
            head = infl_entry;
        end
    end

    assign {out_data, out_sof, out_eof, out_sol, out_eol} = head;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr_q;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        fifo_d       = fifo_q;
        count_d      = occ_after;
        rd_ptr_d     = rd_ptr_q ^ (pop & fifo_nonempty);
        wr_ptr_d     = wr_ptr_q ^ push;
        infl_d       = issue;
        infl_flags_d = issue ? issue_flags : 4'd0;
        if (push) begin
            fifo_d[wr_ptr_q] = infl_entry;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    x_d      = '0;
                    y_d      = '0;
                    addr_d   = '0;
                    state_d  = ((cfg_width == '0) || (cfg_height == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (x_at_end) begin
                        x_d = '0;
                        y_d = y_q + CNT_W'(1);
                    end else begin
                        x_d = x_q + CNT_W'(1);
                    end
                    if (last_px) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (occ_after == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over start and over a same-cycle handshake.
        if (clr) begin
            state_d      = S_IDLE;
            count_d      = 2'd0;
            infl_d       = 1'b0;
            infl_flags_d = 4'd0;
            rd_ptr_d     = 1'b0;
            wr_ptr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            infl_q       <= 1'b0;
            infl_flags_q <= 4'd0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            infl_q       <= infl_d;
            infl_flags_q <= infl_flags_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

`default_nettype wire
